// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared definitions for the FIFO write-port arbiter: the
//               two-state FSM encoding and a constant-foldable clog2 helper
//               used to size index and counter fields.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Minimum of 1 bit so single-valued fields still get a legal width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request at or after ptr, wrapping modulo N_REQ.
//               The request vector is doubled: the low copy is masked below
//               ptr, the high copy is unmasked, so the lowest set bit of the
//               doubled vector is the wrapped round-robin winner.
// Ports       : req [N_REQ]  - request vector
//               ptr          - round-robin start index
//               idx          - winning index (0 when nothing requests)
//               any          - at least one request set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic [clog2(N_REQ)-1:0] idx,
    output logic                    any
);

    localparam int c_idx_w = clog2(N_REQ);

    logic [2*N_REQ-1:0] w_dbl;

    always_comb begin
        w_dbl = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dbl[i]         = req[i] & (i >= int'(ptr));
            w_dbl[i + N_REQ] = req[i];
        end
    end

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 2*N_REQ-1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                idx = (i >= N_REQ) ? c_idx_w'(i - N_REQ) : c_idx_w'(i);
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing the async_fifo write port among
//               N_REQ valid/ready/last requesters. A grant lasts until the
//               holder's last beat or MAX_BURST beats; every beat is gated
//               by FULL. One IDLE cycle separates consecutive grants.
// Ports       : wclk, w_rst (async, active-low)
//               req_valid/req_last/req_data/req_ready - requester side
//               FULL/w_inc/WR_DATA                    - FIFO write side
//               gnt_id, busy                          - grant status
// Options     : FIFO_ARB_PRIO_EN - requester 0 gets strict priority; the
//               remaining requesters rotate among themselves.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                        wclk,
    input  logic                        w_rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        FULL,
    output logic                        w_inc,
    output logic [DATA_WIDTH-1:0]       WR_DATA,
    output logic [clog2(N_REQ)-1:0]     gnt_id,
    output logic                        busy
);

    localparam int c_gnt_w = clog2(N_REQ);
    localparam int c_cnt_w = clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
    localparam logic [c_gnt_w-1:0] c_last_id   = c_gnt_w'(N_REQ - 1);

    logic [0:0]            r_state;
    logic [c_gnt_w-1:0]    r_gnt_id;
    logic [c_gnt_w-1:0]    r_rr_ptr;
    logic [c_cnt_w-1:0]    r_beat_cnt;

    logic                  w_in_grant;
    logic                  w_beat;
    logic                  w_end;
    logic [c_cnt_w-1:0]    w_cnt_inc;
    logic [c_gnt_w-1:0]    w_next_ptr;
    logic [c_gnt_w-1:0]    w_next_gnt;
    logic [c_gnt_w-1:0]    w_rr_idx;
    logic                  w_rr_any;
    logic [N_REQ-1:0]      w_pick_req;
    logic                  w_ptr_upd;
    logic [DATA_WIDTH-1:0] w_gnt_data;

    // ---------------------------------------------------------------- picker
`ifdef FIFO_ARB_PRIO_EN
    // Requester 0 bypasses the rotation; the rest rotate among themselves.
    assign w_pick_req = {req_valid[N_REQ-1:1], 1'b0};
    assign w_next_gnt = req_valid[0] ? '0 : w_rr_idx;
    assign w_ptr_upd  = (r_gnt_id != '0);
`else
    assign w_pick_req = req_valid;
    assign w_next_gnt = w_rr_idx;
    assign w_ptr_upd  = 1'b1;
`endif

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (w_pick_req),
        .ptr   (r_rr_ptr),
        .idx   (w_rr_idx),
        .any   (w_rr_any)
    );

    // ------------------------------------------------------- handshake/data
    assign w_in_grant = (r_state == ST_GRANT);
    assign w_gnt_data = req_data[int'(r_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    assign w_beat     = w_in_grant & req_valid[r_gnt_id] & ~FULL;
    assign w_cnt_inc  = r_beat_cnt + c_cnt_w'(1);
    assign w_end      = w_beat & (req_last[r_gnt_id] | (w_cnt_inc == c_max_burst));
    assign w_next_ptr = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + c_gnt_w'(1);

    always_comb begin
        req_ready = '0;
        if (w_in_grant && !FULL) begin
            req_ready[r_gnt_id] = 1'b1;
        end
    end

    assign w_inc   = w_beat;
    assign WR_DATA = w_in_grant ? w_gnt_data : '0;
    assign gnt_id  = r_gnt_id;
    assign busy    = w_in_grant;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge wclk or negedge w_rst) begin
        if (!w_rst) begin
            r_state    <= ST_IDLE;
            r_gnt_id   <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_state    <= ST_GRANT;
                        r_gnt_id   <= w_next_gnt;
                        r_beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    // FULL suppresses w_beat, so the count and grant hold.
                    if (w_beat) begin
                        r_beat_cnt <= w_cnt_inc;
                        if (w_end) begin
                            r_state <= ST_IDLE;
                            if (w_ptr_upd) begin
                                r_rr_ptr <= w_next_ptr;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The picker's any flag is redundant with |req_valid in the FSM.
    logic w_unused;
    assign w_unused = w_rr_any;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of `async_fifo` between `N_REQ` requesters in the `wclk` domain. Each requester offers bursts over a valid/ready/last handshake. The arbiter grants one requester at a time and drives `w_inc`/`WR_DATA` into the FIFO, gating every beat on `FULL`. A grant is held until the requester's last beat or until `MAX_BURST` beats, so a single requester cannot starve the others.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of one beat; matches the FIFO `DATA_WIDTH`.
- `N_REQ`, default 4: number of requesters, range 2..16.
- `MAX_BURST`, default 8: maximum beats per grant, range 1..255.

Ports (clock and reset first):
- `wclk` in 1: the single clock, rising edge, same as the FIFO write clock.
- `w_rst` in 1: reset, asynchronous, active-low.
- `req_valid` in `N_REQ`: per-requester beat valid.
- `req_last` in `N_REQ`: per-requester last beat of burst; qualified by valid.
- `req_data` in `N_REQ*DATA_WIDTH`: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out `N_REQ`: per-requester beat accepted.
- `FULL` in 1: FIFO full flag from the FIFO write side.
- `w_inc` out 1: FIFO write strobe.
- `WR_DATA` out `DATA_WIDTH`: FIFO write data.
- `gnt_id` out `clog2(N_REQ)`: index of the current grant holder; valid while `busy`.
- `busy` out 1: high in `GRANT`.

## Operation
- FSM has two states, `IDLE` and `GRANT`.
- `IDLE`: if `|req_valid` is set, the round-robin picker selects the first valid index at or after `rr_ptr`, wrapping modulo `N_REQ`. On the next edge the FSM registers `gnt_id`, clears `beat_cnt`, and moves to `GRANT`. If no request is valid, it stays in `IDLE`.
- `GRANT`:
  - `req_ready[gnt_id] = ~FULL`. All other `req_ready` bits are 0.
  - A beat occurs when `req_valid[gnt_id] & req_ready[gnt_id]`.
  - On a beat: `w_inc = 1`, `WR_DATA = req_data[gnt_id]`, and `beat_cnt` increments.
  - Grant ends on a beat with `req_last[gnt_id]=1`, or on the beat that brings `beat_cnt` to `MAX_BURST`.
  - At grant end: FSM returns to `IDLE` and `rr_ptr <= (gnt_id+1) mod N_REQ`.
  - Requester valid dropping mid-burst does not end the grant. The arbiter waits with no timeout.
- Outside `GRANT`: `w_inc = 0` and `req_ready = 0`.
- Outputs are combinational from registered state plus `FULL` and `req_*`. The FIFO memory captures `WR_DATA` on the `wclk` edge with `w_inc` high.
- `FULL` asserted: no beat occurs, `w_inc` is guaranteed 0, the grant is held, and `beat_cnt` is unchanged. The arbiter never writes while `FULL=1`.
- `beat_cnt` is `clog2(MAX_BURST+1)` bits and never wraps.
- Reset (`w_rst=0`), any time including mid-burst:
  - FSM goes to `IDLE`; `rr_ptr`, `gnt_id` and `beat_cnt` go to 0.
  - `busy`, `w_inc` and `req_ready` are 0 while reset is held.
  - `WR_DATA` is 0 outside `GRANT`.
  - A partially sent burst is abandoned. The requester must restart it.

## Timing
- Arbitration latency: request valid in `IDLE` gives the first possible beat 1 cycle later.
- Beat throughput: 1 beat per cycle while `FULL=0`.
- One `IDLE` bubble cycle occurs between consecutive grants. A back-to-back burst from the same requester pays this bubble too.
- `req_ready` and `w_inc` respond to `FULL` combinationally in the same cycle. There is no skid buffer.
- `FULL` is pessimistic (synchronized read pointer), so the arbiter never overruns the FIFO.

## Configuration
- `FIFO_ARB_PRIO_EN` defined: requester 0 has strict priority. In `IDLE`, if `req_valid[0]=1` it is picked regardless of `rr_ptr`. `rr_ptr` is not updated when grant 0 ends. Requesters 1..`N_REQ-1` rotate round-robin among themselves. `MAX_BURST` still bounds requester 0.
- Undefined: pure round-robin over all `N_REQ` requesters.

## Structure
- Shared package `fifo_arb_pkg` holds the state encoding (`ST_IDLE=1'b0`, `ST_GRANT=1'b1`) and the `clog2` helper function.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[N_REQ]`, `ptr`.
  - Outputs: `idx`, `any`.
  - Implemented as a double-width masked priority encoder.
- The top holds the FSM, counters, data mux and handshake logic.

## Test plan
- Single burst: requester 2 sends 3 beats 0xA1,0xA2,0xA3 with last on the third, `FULL=0` -> `gnt_id=2` one cycle after valid; `w_inc` high 3 consecutive cycles with those values; `busy` drops next cycle; `rr_ptr=3`.
- Round-robin fairness: all 4 requesters always valid with 1-beat bursts -> grant order 0,1,2,3,0, with one `IDLE` cycle between grants.
- Burst cap: requester 1 sends 20 beats with no last, `MAX_BURST=8` -> exactly 8 beats, then grant moves to the next valid requester; the remaining 12 beats are sent in later grants.
- Backpressure: `FULL` asserted for 5 cycles mid-burst -> `w_inc=0` and `req_ready=0` for those cycles; `beat_cnt` holds; the burst resumes with no lost or duplicate data.
- Reset mid-burst: `w_rst` pulsed low after beat 2 of 4 -> all outputs 0 immediately; after release FSM is in `IDLE` with `rr_ptr=0`.
- `FIFO_ARB_PRIO_EN`: requesters 0 and 3 valid continuously -> requester 0 wins every arbitration. Without the macro, the two alternate.
